// File: rtl/cpu_pkg.sv
// Shared pipeline constants for the 8-bit core. The decode stage, the
// writeback stage and the register file all use these.
package cpu_pkg;
  localparam int DATA_W = 8;

  localparam logic [1:0] WEN_NONE = 2'b00;
  localparam logic [1:0] WEN_RD   = 2'b01;
  localparam logic [1:0] WEN_SP   = 2'b10;
  localparam logic [1:0] WEN_BOTH = 2'b11;

  localparam logic [1:0] SP_ADDR  = 2'd3;

  // rd and SP cannot both be written when rd is the SP itself
  function automatic logic sp_clash(input logic [1:0] wen, input logic [1:0] rd);
    return (wen == WEN_BOTH) && (rd == SP_ADDR);
  endfunction
endpackage

// File: rtl/wb_stage_if.sv
// Bundle of the MEM-side inputs, register-file write port, forwarding
// outputs and status signals of the writeback stage.
interface wb_stage_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic              mem_valid;
  logic [1:0]        mem_wen;
  logic [1:0]        mem_rd;
  logic              mem_is_load;
  logic [DATA_W-1:0] mem_alu_result;
  logic [DATA_W-1:0] mem_load_data;
  logic [DATA_W-1:0] mem_sp_new;
  logic              wb_stall;
  logic              wb_flush;

  logic [1:0]        reg_file_wen;
  logic [1:0]        dest_addr;
  logic [DATA_W-1:0] data_in1;
  logic [DATA_W-1:0] data_in2;
  logic              fwd_rd_valid;
  logic [1:0]        fwd_rd;
  logic [DATA_W-1:0] fwd_rd_data;
  logic              fwd_sp_valid;
  logic [DATA_W-1:0] fwd_sp_data;
  logic              sp_conflict;
  logic [CNT_W-1:0]  retired;

  modport master (
    output mem_valid, mem_wen, mem_rd, mem_is_load, mem_alu_result,
           mem_load_data, mem_sp_new, wb_stall, wb_flush,
    input  reg_file_wen, dest_addr, data_in1, data_in2, fwd_rd_valid,
           fwd_rd, fwd_rd_data, fwd_sp_valid, fwd_sp_data, sp_conflict, retired
  );

  modport slave (
    input  mem_valid, mem_wen, mem_rd, mem_is_load, mem_alu_result,
           mem_load_data, mem_sp_new, wb_stall, wb_flush,
    output reg_file_wen, dest_addr, data_in1, data_in2, fwd_rd_valid,
           fwd_rd, fwd_rd_data, fwd_sp_valid, fwd_sp_data, sp_conflict, retired
  );
endinterface

// File: rtl/wb_pipe_reg.sv
// MEM/WB capture register: flush beats stall, stall holds, otherwise load.
module wb_pipe_reg #(
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  input  logic [1:0]        in_wen,
  input  logic [1:0]        in_rd,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [DATA_W-1:0] in_sp_new,
  output logic              valid,
  output logic [1:0]        wen,
  output logic [1:0]        rd,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] sp_new
);
  import cpu_pkg::*;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid  <= 1'b0;
      wen    <= WEN_NONE;
      rd     <= 2'd0;
      wdata  <= '0;
      sp_new <= '0;
    end else if (flush) begin
      // fields are left as-is; only valid matters for a bubble
      valid <= 1'b0;
    end else if (!stall) begin
      valid  <= in_valid;
      wen    <= in_wen;
      rd     <= in_rd;
      wdata  <= in_wdata;
      sp_new <= in_sp_new;
    end
  end
endmodule

// File: rtl/wb_stage.sv
// MEM/WB stage: captures the retiring instruction, drives the register file
// write port once per instruction, forwards pending writes and counts retires.
module wb_stage #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic      clk,
  input  logic      reset,
  wb_stage_if.slave bus
);
  import cpu_pkg::*;

  logic              valid, issued, issue_now, capture, clash;
  logic [1:0]        wen, rd, wen_cap;
  logic [DATA_W-1:0] wdata, sp_new, wdata_cap;
  logic              sp_conflict_q;
  logic [CNT_W-1:0]  retired_q;

  assign clash     = bus.mem_valid && sp_clash(bus.mem_wen, bus.mem_rd);
  assign wen_cap   = clash ? WEN_SP : bus.mem_wen;
  assign wdata_cap = bus.mem_is_load ? bus.mem_load_data : bus.mem_alu_result;
  assign capture   = !bus.wb_flush && !bus.wb_stall;

  wb_pipe_reg #(.DATA_W(DATA_W)) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.wb_flush),
    .stall     (bus.wb_stall),
    .in_valid  (bus.mem_valid),
    .in_wen    (wen_cap),
    .in_rd     (bus.mem_rd),
    .in_wdata  (wdata_cap),
    .in_sp_new (bus.mem_sp_new),
    .valid     (valid),
    .wen       (wen),
    .rd        (rd),
    .wdata     (wdata),
    .sp_new    (sp_new)
  );

  // An occupied stage writes only in its first cycle; later stalled cycles are issued.
  assign issue_now = valid && !issued;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issued        <= 1'b0;
      sp_conflict_q <= 1'b0;
      retired_q     <= '0;
    end else begin
      retired_q <= retired_q + CNT_W'(issue_now);
      if (bus.wb_flush)      issued <= 1'b0;
      else if (bus.wb_stall) issued <= issued | valid;
      else                   issued <= 1'b0;
      if (capture && clash) sp_conflict_q <= 1'b1;
    end
  end

  assign bus.reg_file_wen = issue_now ? wen : WEN_NONE;
  assign bus.dest_addr    = rd;
  assign bus.data_in1     = wdata;
  assign bus.data_in2     = sp_new;

  assign bus.fwd_rd_valid = valid && wen[0];
  assign bus.fwd_rd       = rd;
  assign bus.fwd_rd_data  = wdata;
  assign bus.fwd_sp_valid = valid && wen[1];
  assign bus.fwd_sp_data  = sp_new;

  assign bus.sp_conflict  = sp_conflict_q;
  assign bus.retired      = retired_q;
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: expected register-file writes are queued when an
// instruction is accepted and popped by a monitor when the write port fires.
module tb_wb_stage;
  import cpu_pkg::*;

  localparam int DW = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wb_stage_if #(.DATA_W(DW), .CNT_W(CW)) bus();
  wb_stage #(.DATA_W(DW), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [1:0]    wen;
    logic [1:0]    addr;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
  } wr_t;

  wr_t           sb_q[$];
  wr_t           mon_e;
  int            checks = 0;
  int            failures = 0;
  logic [CW-1:0] exp_retired = '0;
  logic          exp_conflict = 1'b0;
  logic [CW-1:0] r0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] w, input logic [1:0] r, input logic ld,
                       input logic [DW-1:0] alu, input logic [DW-1:0] lw, input logic [DW-1:0] sp);
    bus.mem_valid      = v;
    bus.mem_wen        = w;
    bus.mem_rd         = r;
    bus.mem_is_load    = ld;
    bus.mem_alu_result = alu;
    bus.mem_load_data  = lw;
    bus.mem_sp_new     = sp;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Reference model: every accepted valid instruction retires exactly once,
  // and writes whatever it requested, with SP winning a clash on register 3.
  always @(posedge clk) begin
    if (!reset && bus.mem_valid && !bus.wb_flush && !bus.wb_stall) begin
      wr_t e;
      e.wen  = bus.mem_wen;
      if (bus.mem_wen == 2'b11 && bus.mem_rd == 2'd3) begin
        e.wen = 2'b10;
        exp_conflict = 1'b1;
      end
      e.addr = bus.mem_rd;
      e.d1   = bus.mem_is_load ? bus.mem_load_data : bus.mem_alu_result;
      e.d2   = bus.mem_sp_new;
      if (e.wen != 2'b00) sb_q.push_back(e);
      exp_retired = exp_retired + 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!reset && bus.reg_file_wen !== WEN_NONE) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got wen=%0d addr=%0d expected no write at %0t",
                 bus.reg_file_wen, bus.dest_addr, $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("wr_port", {12'd0, bus.reg_file_wen, bus.dest_addr, bus.data_in1, bus.data_in2}, {12'd0, mon_e});
        if (mon_e.wen[0]) check("fwd_rd_data", {24'd0, bus.fwd_rd_data}, {24'd0, mon_e.d1});
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_wen"},  {30'd0, bus.reg_file_wen}, 32'd0);
    check({tag, "_dest"}, {30'd0, bus.dest_addr}, 32'd0);
    check({tag, "_d1"},   {24'd0, bus.data_in1}, 32'd0);
    check({tag, "_d2"},   {24'd0, bus.data_in2}, 32'd0);
    check({tag, "_fwd"},  {30'd0, bus.fwd_rd_valid, bus.fwd_sp_valid}, 32'd0);
    check({tag, "_conf"}, {31'd0, bus.sp_conflict}, 32'd0);
    check({tag, "_ret"},  {16'd0, bus.retired}, 32'd0);
  endtask

  initial begin
    int n;
    logic v, st, fl;
    logic [1:0] w, r;
    drive(0, 0, 0, 0, 0, 0, 0);
    bus.wb_stall = 1'b0;
    bus.wb_flush = 1'b0;
    #1 check_all_zero("reset");
    cyc();
    reset = 1'b0;

    // ALU write
    drive(1, 2'b01, 2'd1, 0, 8'h5A, 8'h00, 8'h00);
    cyc();
    check("alu_wen",  {30'd0, bus.reg_file_wen}, 32'd1);
    check("alu_dest", {30'd0, bus.dest_addr}, 32'd1);
    check("alu_d1",   {24'd0, bus.data_in1}, 32'h5A);
    check("alu_fwd",  {31'd0, bus.fwd_rd_valid}, 32'd1);
    check("alu_ret0", {16'd0, bus.retired}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    cyc();
    check("alu_ret1", {16'd0, bus.retired}, 32'd1);

    // Load select
    drive(1, 2'b01, 2'd2, 1, 8'h11, 8'h77, 8'h00);
    cyc();
    check("ld_d1",  {24'd0, bus.data_in1}, 32'h77);
    check("ld_fwd", {24'd0, bus.fwd_rd_data}, 32'h77);

    // POP-style rd+SP
    drive(1, 2'b11, 2'd0, 1, 8'h99, 8'h3C, 8'h04);
    cyc();
    check("pop_wen",  {30'd0, bus.reg_file_wen}, 32'd3);
    check("pop_d1",   {24'd0, bus.data_in1}, 32'h3C);
    check("pop_d2",   {24'd0, bus.data_in2}, 32'h04);
    check("pop_conf", {31'd0, bus.sp_conflict}, 32'd0);

    // Conflict: rd=3 with both writes
    drive(1, 2'b11, 2'd3, 0, 8'h99, 8'h00, 8'h02);
    cyc();
    check("conf_wen",  {30'd0, bus.reg_file_wen}, 32'd2);
    check("conf_d2",   {24'd0, bus.data_in2}, 32'h02);
    check("conf_flag", {31'd0, bus.sp_conflict}, 32'd1);
    check("conf_fwd",  {30'd0, bus.fwd_rd_valid, bus.fwd_sp_valid}, 32'd1);

    // Stall for three cycles
    drive(1, 2'b01, 2'd1, 0, 8'h21, 8'h00, 8'h00);
    cyc();
    r0 = bus.retired;
    check("stall_wen0", {30'd0, bus.reg_file_wen}, 32'd1);
    bus.wb_stall = 1'b1;
    drive(1, 2'b01, 2'd2, 0, 8'hEE, 8'h00, 8'h00);
    for (int i = 1; i < 3; i++) begin
      cyc();
      check("stall_wen",  {30'd0, bus.reg_file_wen}, 32'd0);
      check("stall_fwd",  {31'd0, bus.fwd_rd_valid}, 32'd1);
      check("stall_data", {24'd0, bus.fwd_rd_data}, 32'h21);
    end
    bus.wb_stall = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    cyc();
    check("stall_ret", {16'd0, bus.retired}, {16'd0, r0 + 16'd1});
    check("conf_sticky", {31'd0, bus.sp_conflict}, 32'd1);

    // Flush with a pending write
    drive(1, 2'b01, 2'd2, 0, 8'h44, 8'h00, 8'h00);
    cyc();
    r0 = bus.retired;
    check("flush_wen0", {30'd0, bus.reg_file_wen}, 32'd1);
    bus.wb_flush = 1'b1;
    drive(1, 2'b01, 2'd1, 0, 8'hCC, 8'h00, 8'h00);
    cyc();
    check("flush_wen1", {30'd0, bus.reg_file_wen}, 32'd0);
    check("flush_fwd",  {31'd0, bus.fwd_rd_valid}, 32'd0);
    check("flush_ret",  {16'd0, bus.retired}, {16'd0, r0 + 16'd1});
    bus.wb_flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    cyc();
    check("flush_ret2", {16'd0, bus.retired}, {16'd0, r0 + 16'd1});

    // Reset mid-stall
    drive(1, 2'b01, 2'd1, 0, 8'h66, 8'h00, 8'h00);
    cyc();
    bus.wb_stall = 1'b1;
    cyc();
    #2 reset = 1'b1;
    sb_q.delete();
    exp_retired  = '0;
    exp_conflict = 1'b0;
    #1 check_all_zero("rst_async");
    cyc();
    check("rst_nowrite", {30'd0, bus.reg_file_wen}, 32'd0);
    reset = 1'b0;
    bus.wb_stall = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      w  = 2'($urandom_range(0, 3));
      r  = 2'($urandom_range(0, 3));
      if (!v && w == 2'b11 && r == 2'd3) r = 2'd0;
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 9) == 0);
      drive(v, w, r, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom));
      bus.wb_stall = st;
      bus.wb_flush = fl;
      cyc();
    end
    bus.wb_stall = 1'b0;
    bus.wb_flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc();
    check("rnd_drain",   sb_q.size(), 32'd0);
    check("rnd_retired", {16'd0, bus.retired}, {16'd0, exp_retired});
    check("rnd_conf",    {31'd0, bus.sp_conflict}, {31'd0, exp_conflict});

    // Counter wrap
    n = 65535 - int'(exp_retired);
    drive(1, 2'b00, 2'd0, 0, 8'h00, 8'h00, 8'h00);
    repeat (n) cyc();
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc();
    check("wrap_max", {16'd0, bus.retired}, 32'h0000FFFF);
    drive(1, 2'b00, 2'd0, 0, 8'h00, 8'h00, 8'h00);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc();
    check("wrap_zero", {16'd0, bus.retired}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register plus writeback control for the 8-bit pipeline.
- Captures the instruction retiring from MEM and selects the ALU result or the load data.
- Drives the register file write port (reg_file_wen, dest_addr, data_in1, data_in2) exactly once per instruction.
- Exports forwarding values for EX and counts retired instructions.

Parameters:
DATA_W, 8, datapath width
CNT_W, 16, retire counter width

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  asynchronous, active-high; clears all state immediately
mem_valid  in  1  MEM holds a real instruction
mem_wen  in  2  requested write: 00 none, 01 rd, 10 SP, 11 rd+SP
mem_rd  in  2  destination register
mem_is_load  in  1  data_in1 comes from mem_load_data, not mem_alu_result
mem_alu_result  in  DATA_W  ALU result
mem_load_data  in  DATA_W  memory read data
mem_sp_new  in  DATA_W  updated SP value
wb_stall  in  1  hold stage contents
wb_flush  in  1  replace captured instruction with a bubble
reg_file_wen  out  2  to register file
dest_addr  out  2  to register file
data_in1  out  DATA_W  to register file
data_in2  out  DATA_W  to register file (SP)
fwd_rd_valid  out  1  stage holds a pending or just-issued rd write
fwd_rd  out  2  forwarded destination
fwd_rd_data  out  DATA_W  forwarded rd value
fwd_sp_valid  out  1  stage holds an SP write
fwd_sp_data  out  DATA_W  forwarded SP value
sp_conflict  out  1  sticky: a rd=3 with wen=11 was seen
retired  out  CNT_W  count of retired instructions

Behaviour:
- Reset (async): stage valid=0, issued=0, stored fields=0, sp_conflict=0, retired=0.
  - All outputs read 0 while in reset, including reg_file_wen=00.
- Capture at posedge, in priority order:
  - wb_flush: valid<=0, issued<=0 (flush wins over stall).
  - else wb_stall: hold all fields; issued<=1 if valid.
  - else load the mem_* inputs (valid<=mem_valid, issued<=0).
- Data select at capture: wdata = mem_is_load ? mem_load_data : mem_alu_result.
  - wdata is stored in one register; the source fields are not kept.
- Conflict rule at capture: mem_wen=11 with mem_rd=3 is stored as wen=10 (SP wins) and sets sp_conflict.
  - sp_conflict is cleared only by reset.
- Write port, combinational from stored state:
  - If valid && !issued: reg_file_wen=stored wen, dest_addr=rd, data_in1=wdata, data_in2=sp_new.
  - Otherwise reg_file_wen=00; dest_addr and data lines still show stored values.
  - Consequence: an instruction held by wb_stall writes the register file only once, in its first occupied cycle.
- Latency: mem_* presented before edge N is captured at N; the register file write commits at edge N+1.
- Forwarding:
  - fwd_rd_valid = valid && wen[0].
  - fwd_sp_valid = valid && wen[1].
  - Stays asserted while stalled so EX never reads a stale register.
- Retire counter: increments by 1 at each posedge where valid && !issued, whether or not the instruction writes.
  - Bubbles never count.
  - Wraps from 2^CNT_W-1 to 0 silently.
- Flush in the same cycle as a pending write:
  - The write already on the port commits at that edge and retired increments.
  - The stage then becomes a bubble.
- Reset mid-stall: state clears immediately and no write is issued.

Decomposition:
- Shared package cpu_pkg holds:
  - WEN_NONE=2'b00, WEN_RD=2'b01, WEN_SP=2'b10, WEN_BOTH=2'b11
  - SP_ADDR=2'd3
  - DATA_W
- The register file and the decode stage use the same constants.
- One natural sub-module, wb_pipe_reg: the flush/stall/capture register for {valid, wen, rd, wdata, sp_new}.
  - Issue logic, forwarding, conflict flag and counter stay in wb_stage.

Test Plan:
- ALU write: mem_valid=1, wen=01, rd=1, alu=0x5A, is_load=0 -> next cycle reg_file_wen=01, dest_addr=1, data_in1=0x5A, fwd_rd_valid=1; retired 0->1.
- Load select: is_load=1, load=0x77, alu=0x11, wen=01, rd=2 -> data_in1=0x77, fwd_rd_data=0x77.
- POP-style: wen=11, rd=0, load=0x3C, sp_new=0x04 -> reg_file_wen=11, data_in1=0x3C, data_in2=0x04; sp_conflict stays 0.
- Conflict: wen=11, rd=3, sp_new=0x02 -> reg_file_wen=10, data_in2=0x02, sp_conflict=1 and stays 1 afterwards.
- Stall for 3 cycles after capturing wen=01, rd=1:
  - reg_file_wen=01 in the first cycle, 00 in the next two.
  - fwd_rd_valid=1 throughout.
  - retired increments exactly once.
- Flush and reset:
  - wb_flush with a pending write -> write commits and the following cycle is a bubble (reg_file_wen=00, retired unchanged).
  - reset asserted mid-cycle -> all outputs 0 without waiting for clk.
